// File: rtl/chess_move_sequencer.sv
// rtl/chess_move_sequencer.sv - host-side move enumerator for the chess move-generator core
//
// Drives the core's registered 8-bit command/data bus. It walks victims
// (outer loop) and aggressors (inner loop) in the order the core reports
// them, and presents each move on a valid/ready stream.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   start, wtm               begin enumeration for side wtm (accepted in IDLE only)
//   pc_valid/pc_ready        piece-write request / accept (IDLE only)
//   pc_square, pc_piece      square and {color,type} for a piece write
//   cmd_addr, cmd_data       registered command bus to the core
//   core_result              core answer: [7] illegal, [6] none, [5:0] square
//   mv_valid/mv_ready        move stream handshake
//   mv_from, mv_to           aggressor / victim square of the presented move
//   busy, done, pos_illegal  run status (done is a level until the next start)
//   move_count               moves emitted in this run (saturating)

module chess_move_sequencer #(
  parameter int SCAN_W = 6,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              wtm,
  input  logic              pc_valid,
  output logic              pc_ready,
  input  logic [SCAN_W-1:0] pc_square,
  input  logic [3:0]        pc_piece,
  output logic [7:0]        cmd_addr,
  output logic [7:0]        cmd_data,
  input  logic [7:0]        core_result,
  output logic              mv_valid,
  input  logic              mv_ready,
  output logic [SCAN_W-1:0] mv_from,
  output logic [SCAN_W-1:0] mv_to,
  output logic              busy,
  output logic              done,
  output logic              pos_illegal,
  output logic [CNT_W-1:0]  move_count
);

  localparam int NSQ = 1 << SCAN_W;

  typedef enum logic [3:0] {
    S_IDLE, S_EN_V, S_MASK_V, S_FIND_V, S_WAIT_V,
    S_EN_A, S_FIND_A, S_WAIT_A, S_EMIT, S_CLR_A, S_DONE
  } state_t;

  state_t state, next_state;

  logic [SCAN_W-1:0] scan, scan_next;
  logic [SCAN_W-1:0] victim, aggr;
  logic              side;
  logic [NSQ-1:0]    victim_done;
  logic [7:0]        cmd_addr_next, cmd_data_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start) next_state = S_EN_V;
      S_EN_V:   next_state = S_MASK_V;
      S_MASK_V: if (scan == {SCAN_W{1'b1}}) next_state = S_FIND_V;
      S_FIND_V: next_state = S_WAIT_V;
      S_WAIT_V: next_state = (core_result[7] || core_result[6]) ? S_DONE : S_EN_A;
      S_EN_A:   next_state = S_FIND_A;
      S_FIND_A: next_state = S_WAIT_A;
      S_WAIT_A: next_state = core_result[6] ? S_EN_V : S_EMIT;
      S_EMIT:   if (mv_ready) next_state = S_CLR_A;
      S_CLR_A:  next_state = S_FIND_A;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // The command bus is registered, so the command belonging to a state is
  // computed from next_state and lands on the bus exactly while that state
  // is current. The core's answer then arrives during the following WAIT state.
  always_comb begin
    scan_next = scan;
    if (state == S_EN_V)        scan_next = '0;
    else if (state == S_MASK_V) scan_next = scan + SCAN_W'(1);

    cmd_addr_next = 8'h00;
    cmd_data_next = 8'h00;
    if (state == S_IDLE && !start && pc_valid) begin
      cmd_addr_next = {4'hB, 2'b00, pc_square[5:4]};
      cmd_data_next = {pc_square[3:0], pc_piece};
    end else begin
      case (next_state)
        S_EN_V, S_EN_A: cmd_addr_next = 8'hC0;
        S_MASK_V: begin
          // Victims already exhausted are hidden from the next FIND-VICTIM.
          if (victim_done[scan_next]) begin
            cmd_addr_next = {4'hD, 2'b00, scan_next[5:4]};
            cmd_data_next = {scan_next[3:0], 4'b0000};
          end
        end
        S_FIND_V: cmd_addr_next = {4'hE, side, 3'b000};
        S_FIND_A: begin
          cmd_addr_next = {4'hF, side, 1'b0, victim[5:4]};
          cmd_data_next = {victim[3:0], 4'b0000};
        end
        S_CLR_A: begin
          // Hide the aggressor just emitted so the core offers the next one.
          cmd_addr_next = {4'hD, 2'b00, aggr[5:4]};
          cmd_data_next = {aggr[3:0], 4'b0000};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_addr    <= 8'h00;
      cmd_data    <= 8'h00;
      scan        <= '0;
      victim      <= '0;
      aggr        <= '0;
      side        <= 1'b0;
      victim_done <= '0;
      move_count  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pos_illegal <= 1'b0;
    end else begin
      cmd_addr <= cmd_addr_next;
      cmd_data <= cmd_data_next;
      scan     <= scan_next;
      case (state)
        S_IDLE: begin
          if (start) begin
            side        <= wtm;
            victim_done <= '0;
            move_count  <= '0;
            done        <= 1'b0;
            pos_illegal <= 1'b0;
            busy        <= 1'b1;
          end
        end
        S_WAIT_V: begin
          if (core_result[7])       pos_illegal <= 1'b1;
          else if (!core_result[6]) victim      <= core_result[SCAN_W-1:0];
        end
        S_WAIT_A: begin
          if (core_result[6]) victim_done[victim] <= 1'b1;
          else                aggr                <= core_result[SCAN_W-1:0];
        end
        S_EMIT: begin
          if (mv_ready && move_count != {CNT_W{1'b1}})
            move_count <= move_count + CNT_W'(1);
        end
        S_DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign pc_ready = (state == S_IDLE);
  assign mv_valid = (state == S_EMIT);
  assign mv_from  = aggr;
  assign mv_to    = victim;

endmodule

// File: tb/tb_chess_move_sequencer.sv
// tb/tb_chess_move_sequencer.sv - directed bench for chess_move_sequencer with a behavioural core

module tb_chess_move_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       wtm = 1'b0;
  logic       pc_valid = 1'b0;
  logic       pc_ready;
  logic [5:0] pc_square = '0;
  logic [3:0] pc_piece = '0;
  logic [7:0] cmd_addr, cmd_data;
  logic [7:0] core_result = 8'h40;
  logic       mv_valid;
  logic       mv_ready = 1'b0;
  logic [5:0] mv_from, mv_to;
  logic       busy, done, pos_illegal;
  logic [7:0] move_count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  chess_move_sequencer #(.SCAN_W(6), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .wtm(wtm),
    .pc_valid(pc_valid), .pc_ready(pc_ready), .pc_square(pc_square), .pc_piece(pc_piece),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .core_result(core_result),
    .mv_valid(mv_valid), .mv_ready(mv_ready), .mv_from(mv_from), .mv_to(mv_to),
    .busy(busy), .done(done), .pos_illegal(pos_illegal), .move_count(move_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural move-generator core ----------------
  // Victim value: empty 0, pawn 1 .. queen 5, highest first, ties lowest square.
  // Aggressor: lowest piece type first, ties lowest square. Pawns never attack here.
  logic [3:0] board [64];
  logic       en    [64];

  function automatic int iabs(int v); return (v < 0) ? -v : v; endfunction
  function automatic int sgn(int v);  return (v > 0) ? 1 : ((v < 0) ? -1 : 0); endfunction

  function automatic bit is_empty(int s); return board[s][2:0] == 3'd7; endfunction
  function automatic bit own(int s, bit w); return !is_empty(s) && board[s][3] == w; endfunction

  function automatic bit path_clear(int a, int t);
    int r, f, sr, sf;
    sr = sgn(t / 8 - a / 8);
    sf = sgn(t % 8 - a % 8);
    r = a / 8 + sr;
    f = a % 8 + sf;
    for (int k = 0; k < 8 && (r * 8 + f) != t; k++) begin
      if (!is_empty(r * 8 + f)) return 1'b0;
      r += sr;
      f += sf;
    end
    return 1'b1;
  endfunction

  function automatic bit attacks(int a, int t);
    int dr, df, adr, adf;
    if (a == t) return 1'b0;
    dr = t / 8 - a / 8;  df = t % 8 - a % 8;
    adr = iabs(dr);      adf = iabs(df);
    case (board[a][2:0])
      3'd1: return (adr == 1 && adf == 2) || (adr == 2 && adf == 1);
      3'd2: return (adr == adf) && path_clear(a, t);
      3'd3: return (dr == 0 || df == 0) && path_clear(a, t);
      3'd4: return (adr == adf || dr == 0 || df == 0) && path_clear(a, t);
      3'd5: return (adr <= 1 && adf <= 1);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] find_victim(bit w);
    int best, bsq, v;
    for (int t = 0; t < 64; t++)
      if (!is_empty(t) && board[t][2:0] == 3'd5 && board[t][3] != w)
        for (int a = 0; a < 64; a++)
          if (own(a, w) && attacks(a, t)) return 8'h80;
    best = -1; bsq = 0;
    for (int t = 0; t < 64; t++) begin
      if (en[t] && !own(t, w)) begin
        v = is_empty(t) ? 0 : int'(board[t][2:0]) + 1;
        for (int a = 0; a < 64; a++)
          if (own(a, w) && attacks(a, t) && v > best) begin best = v; bsq = t; end
      end
    end
    return (best < 0) ? 8'h40 : 8'(bsq);
  endfunction

  function automatic logic [7:0] find_aggr(bit w, int t);
    int best, bsq;
    best = 99; bsq = 0;
    for (int a = 0; a < 64; a++)
      if (en[a] && own(a, w) && attacks(a, t) && int'(board[a][2:0]) < best) begin
        best = int'(board[a][2:0]); bsq = a;
      end
    return (best == 99) ? 8'h40 : 8'(bsq);
  endfunction

  logic [7:0] c_addr, c_data, c_res;
  int c_sq;

  initial begin
    for (int i = 0; i < 64; i++) begin board[i] = 4'h7; en[i] = 1'b1; end
  end

  // Command seen during cycle N is executed; its answer is driven during N+1.
  always begin
    @(negedge clk);
    c_addr = cmd_addr;
    c_data = cmd_data;
    c_sq   = int'({c_addr[1:0], c_data[7:4]});
    c_res  = 8'h40;
    case (c_addr[7:4])
      4'hB: board[c_sq] = c_data[3:0];
      4'hC: for (int i = 0; i < 64; i++) en[i] = 1'b1;
      4'hD: en[c_sq] = c_data[0];
      4'hE: c_res = find_victim(c_addr[3]);
      4'hF: c_res = find_aggr(c_addr[3], c_sq);
      default: ;
    endcase
    @(posedge clk);
    #1 core_result = c_res;
  end

  // ---------------- stimulus helpers ----------------
  function automatic int exp_to(int k);
    return (k < 7) ? k + 1 : (k - 6) * 8;
  endfunction

  task automatic put(input int sq, input logic [3:0] pc);
    pc_valid = 1'b1;
    pc_square = 6'(sq);
    pc_piece = pc;
    @(posedge clk); #1;
    pc_valid = 1'b0;
  endtask

  task automatic go(input logic side);
    @(posedge clk); #1;
    wtm = side;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Runs until done, checking every accepted move against the lone-rook order.
  task automatic run_moves(input int budget, output int nm, output int nvalid);
    nm = 0;
    nvalid = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (mv_valid) nvalid++;
      if (mv_valid && mv_ready) begin
        chk("mv_from", 32'(mv_from), 32'd0);
        chk("mv_to", 32'(mv_to), 32'(exp_to(nm)));
        nm++;
      end
      if (done) break;
    end
    chk("done_reached", 32'(done), 32'd1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int nm, nv;
  bit seen;

  initial begin
    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_addr", 32'(cmd_addr), 32'h00);
    chk("rst_cmd_data", 32'(cmd_data), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pc_ready", 32'(pc_ready), 32'd1);
    chk("rst_mv_valid", 32'(mv_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_move_count", 32'(move_count), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // back-to-back piece writes
    put(12, 4'h0);
    chk("set_piece12_addr", 32'(cmd_addr), 32'hB0);
    chk("set_piece12_data", 32'(cmd_data), 32'hC0);
    put(63, 4'hD);
    chk("set_piece63_addr", 32'(cmd_addr), 32'hB3);
    chk("set_piece63_data", 32'(cmd_data), 32'hFD);
    put(12, 4'h7);
    put(63, 4'h7);

    // lone white rook on a1
    put(0, 4'h3);
    mv_ready = 1'b1;
    go(1'b0);
    chk("busy_running", 32'(busy), 32'd1);
    run_moves(4000, nm, nv);
    chk("rook_moves_seen", 32'(nm), 32'd14);
    chk("rook_move_count", 32'(move_count), 32'd14);
    chk("rook_pos_illegal", 32'(pos_illegal), 32'd0);
    chk("rook_busy_end", 32'(busy), 32'd0);

    // back-pressure on the first move
    mv_ready = 1'b0;
    go(1'b0);
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      seen = mv_valid;
    end
    chk("bp_first_valid", 32'(seen), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(mv_valid), 32'd1);
      chk("bp_hold_from", 32'(mv_from), 32'd0);
      chk("bp_hold_to", 32'(mv_to), 32'd1);
      chk("bp_hold_count", 32'(move_count), 32'd0);
    end
    @(posedge clk); #1;
    mv_ready = 1'b1;
    run_moves(4000, nm, nv);
    chk("bp_moves_seen", 32'(nm), 32'd14);
    chk("bp_move_count", 32'(move_count), 32'd14);

    // black king on a8 is attacked by the rook with white to move
    put(56, 4'hD);
    go(1'b0);
    run_moves(1000, nm, nv);
    chk("illegal_flag", 32'(pos_illegal), 32'd1);
    chk("illegal_no_valid", 32'(nv), 32'd0);
    chk("illegal_move_count", 32'(move_count), 32'd0);
    put(56, 4'h7);

    // asynchronous reset in the middle of a victim mask scan
    go(1'b0);
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      seen = (move_count == 8'd3);
    end
    chk("mid_reached_3", 32'(seen), 32'd1);
    repeat (8) @(posedge clk);
    #1;
    chk("mid_busy_before", 32'(busy), 32'd1);
    chk("mid_count_before", 32'(move_count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cmd_addr", 32'(cmd_addr), 32'h00);
    chk("mid_rst_cmd_data", 32'(cmd_data), 32'h00);
    chk("mid_rst_mv_valid", 32'(mv_valid), 32'd0);
    chk("mid_rst_pc_ready", 32'(pc_ready), 32'd1);
    chk("mid_rst_count", 32'(move_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // clean rerun after the reset
    go(1'b0);
    run_moves(4000, nm, nv);
    chk("rerun_moves_seen", 32'(nm), 32'd14);
    chk("rerun_move_count", 32'(move_count), 32'd14);
    chk("rerun_pos_illegal", 32'(pos_illegal), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
